// File: rtl/scan_transfer_ctrl.sv
// scan_transfer_ctrl: drains one of two ping-pong scanner buffers per host
// request. Popped words go through a small show-ahead FIFO to a valid/ready
// output link, and each word carries a last-word marker and a source tag.

module scan_transfer_ctrl_chk (
    input logic clk,
    input logic rst,
    input logic push,
    input logic full
);
    // The pop strobe runs one slot ahead of the FIFO, so a push must never see a full FIFO.
    no_push_when_full: assert property (@(posedge clk) disable iff (!rst) !(push && full));
endmodule

module scan_transfer_ctrl #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              transfer_input,
    input  logic              ready_to_transfer,
    input  logic              ready_to_transfer2,
    input  logic [7:0]        data_count,
    input  logic [7:0]        data_count2,
    input  logic [DATA_W-1:0] rd_data,
    input  logic [DATA_W-1:0] rd_data2,
    output logic              transfer,
    output logic              transfer2,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              out_src,
    output logic              busy,
    output logic [7:0]        frames_done,
    output logic              xfer_abort
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRAIN0 = 2'd1,
        DRAIN1 = 2'd2
    } state_t;

    state_t              state_r, state_s;
    logic                rr_next_r, rr_next_s;
    logic                transfer_s, transfer2_s, xfer_abort_s, busy_s;
    logic [7:0]          frames_done_s;
    logic                push_s, push_last_s, push_src_s, fifo_pop_s, room_s;
    logic [DATA_W-1:0]   push_data_s;

    logic [DATA_W-1:0]   mem_data_r [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] mem_last_r, mem_src_r;
    logic [PTR_W-1:0]    wr_ptr_r, rd_ptr_r;
    logic [CNT_W-1:0]    count_r;

    // Arbitration, pop/completion decode and next-cycle strobe computation.
    always_comb begin
        state_s       = state_r;
        rr_next_s     = rr_next_r;
        xfer_abort_s  = 1'b0;
        frames_done_s = frames_done;
        push_s        = 1'b0;
        push_data_s   = '0;
        push_last_s   = 1'b0;
        push_src_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (!transfer_input && ready_to_transfer && ready_to_transfer2) begin
                    state_s   = rr_next_r ? DRAIN1 : DRAIN0;
                    rr_next_s = ~rr_next_r;
                end else if (!transfer_input && ready_to_transfer) begin
                    state_s   = DRAIN0;
                    rr_next_s = 1'b1;
                end else if (!transfer_input && ready_to_transfer2) begin
                    state_s   = DRAIN1;
                    rr_next_s = 1'b0;
                end else begin
                    state_s   = IDLE;
                end
            end
            DRAIN0: begin
                if (transfer && (data_count != 8'd0)) begin
                    push_s      = 1'b1;
                    push_data_s = rd_data;
                    push_last_s = (data_count == 8'd1);
                    push_src_s  = 1'b0;
                    if (data_count == 8'd1) begin
                        state_s       = IDLE;
                        frames_done_s = frames_done + 8'd1;
                    end else begin
                        state_s = DRAIN0;
                    end
                end else if (transfer) begin
                    // Buffer was flushed under us: end the drain without a last word.
                    state_s      = IDLE;
                    xfer_abort_s = 1'b1;
                end else begin
                    state_s = DRAIN0;
                end
            end
            DRAIN1: begin
                if (transfer2 && (data_count2 != 8'd0)) begin
                    push_s      = 1'b1;
                    push_data_s = rd_data2;
                    push_last_s = (data_count2 == 8'd1);
                    push_src_s  = 1'b1;
                    if (data_count2 == 8'd1) begin
                        state_s       = IDLE;
                        frames_done_s = frames_done + 8'd1;
                    end else begin
                        state_s = DRAIN1;
                    end
                end else if (transfer2) begin
                    state_s      = IDLE;
                    xfer_abort_s = 1'b1;
                end else begin
                    state_s = DRAIN1;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        // Two free slots before this edge leave room for the word still in flight.
        room_s      = (count_r <= CNT_W'(FIFO_DEPTH - 2));
        transfer_s  = (state_s == DRAIN0) && room_s;
        transfer2_s = (state_s == DRAIN1) && room_s;
        busy_s      = (state_s != IDLE);
    end

    assign fifo_pop_s = (count_r != '0) && out_ready;

    // Control state, registered strobes and status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= IDLE;
            rr_next_r   <= 1'b0;
            transfer    <= 1'b0;
            transfer2   <= 1'b0;
            busy        <= 1'b0;
            frames_done <= 8'd0;
            xfer_abort  <= 1'b0;
        end else begin
            state_r     <= state_s;
            rr_next_r   <= rr_next_s;
            transfer    <= transfer_s;
            transfer2   <= transfer2_s;
            busy        <= busy_s;
            frames_done <= frames_done_s;
            xfer_abort  <= xfer_abort_s;
        end
    end

    // Show-ahead FIFO storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_data_r[i] <= '0;
            end
            mem_last_r <= '0;
            mem_src_r  <= '0;
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            count_r    <= '0;
        end else begin
            if (push_s) begin
                mem_data_r[wr_ptr_r] <= push_data_s;
                mem_last_r[wr_ptr_r] <= push_last_s;
                mem_src_r[wr_ptr_r]  <= push_src_s;
                wr_ptr_r             <= wr_ptr_r + PTR_W'(1);
            end
            if (fifo_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, fifo_pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign out_valid = (count_r != '0);
    assign out_data  = mem_data_r[rd_ptr_r];
    assign out_last  = out_valid & mem_last_r[rd_ptr_r];
    assign out_src   = out_valid & mem_src_r[rd_ptr_r];

    scan_transfer_ctrl_chk u_chk (
        .clk  (clk),
        .rst  (rst),
        .push (push_s),
        .full (count_r == CNT_W'(FIFO_DEPTH))
    );
endmodule
